nrf2401_shift_ctrl: RTL

Hardware serial engine for the nRF2401 radio's 3-wire interface (CS, CLK1, DATA) plus CE/DR1 sideband, mapped as an Avalon-MM slave beside the single-bit PIO peripherals. It replaces per-edge software toggling of CLK1/DATA with a byte-wide shifter.
- Software writes a byte and the block generates eight CLK1 periods, driving or sampling DATA MSB-first.
- Software then reads status and the received byte, or takes an interrupt.

---
 rtl/nrf2401_shift_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/nrf2401_shift_ctrl.sv
// Avalon-MM byte shifter for the nRF2401 3-wire config/data interface.
// Software writes TXDATA; the block produces eight CLK1 periods, driving
// DATA from b7 and capturing the pin on each rise, MSB first.
module nrf2401_shift_ctrl #(
  parameter logic [7:0] DIV_RESET = 8'd24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       irq,
  output logic       nrf_clk,
  output logic       nrf_data_out,
  output logic       nrf_data_oe,
  input  logic       nrf_data_in,
  output logic       nrf_cs,
  output logic       nrf_ce,
  input  logic       nrf_dr1
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] div_q, div_d;
  logic       cap_q, cap_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;
  logic       cs_q, cs_d, ce_q, ce_d, dir_q, dir_d, irqen_q, irqen_d;
  logic       din_meta_q, din_s_q, dr1_meta_q, dr1_s_q;

  logic       wr, busy;
  logic [7:0] sh_next;

  assign wr      = chipselect & ~write_n;
  assign busy    = (state_q != IDLE);
  assign sh_next = {sh_q[6:0], cap_q};

  // Two-flop synchronizers for the asynchronous radio inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_meta_q <= 1'b0;
      din_s_q    <= 1'b0;
      dr1_meta_q <= 1'b0;
      dr1_s_q    <= 1'b0;
    end else begin
      din_meta_q <= nrf_data_in;
      din_s_q    <= din_meta_q;
      dr1_meta_q <= nrf_dr1;
      dr1_s_q    <= dr1_meta_q;
    end
  end

  // State and register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      bitcnt_q <= 3'd0;
      sh_q     <= 8'd0;
      rx_q     <= 8'd0;
      div_q    <= DIV_RESET;
      cap_q    <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      cs_q     <= 1'b0;
      ce_q     <= 1'b0;
      dir_q    <= 1'b0;
      irqen_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
      div_q    <= div_d;
      cap_q    <= cap_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      cs_q     <= cs_d;
      ce_q     <= ce_d;
      dir_q    <= dir_d;
      irqen_q  <= irqen_d;
    end
  end

  // Register writes first, then the FSM, so a done-set beats a same-edge clear.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    div_d    = div_q;
    cap_d    = cap_q;
    done_d   = done_q;
    ovr_d    = ovr_q;
    cs_d     = cs_q;
    ce_d     = ce_q;
    dir_d    = dir_q;
    irqen_d  = irqen_q;

    if (wr) begin
      case (address)
        3'd0: begin
          if (busy) begin
            ovr_d = 1'b1;
          end else begin
            sh_d     = writedata;
            bitcnt_d = 3'd0;
            cnt_d    = div_q;
            state_d  = LOW;
            done_d   = 1'b0;
          end
        end
        3'd2: begin
          if (writedata[1]) done_d = 1'b0;
          if (writedata[2]) ovr_d  = 1'b0;
        end
        3'd3: begin
          cs_d    = writedata[0];
          ce_d    = writedata[1];
          irqen_d = writedata[3];
          // Flipping direction mid-byte would fight the radio on DATA.
          if (!busy) dir_d = writedata[2];
        end
        3'd4: div_d = writedata;
        default: ;
      endcase
    end

    case (state_q)
      LOW: begin
        if (cnt_q == 8'd0) begin
          cap_d   = din_s_q;
          cnt_d   = div_q;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HIGH: begin
        if (cnt_q == 8'd0) begin
          sh_d     = sh_next;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            rx_d    = sh_next;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = div_q;
            state_d = LOW;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Zero-latency read mux.
  always_comb begin
    readdata = 8'd0;
    case (address)
      3'd0: readdata = sh_q;
      3'd1: readdata = rx_q;
      3'd2: readdata = {4'd0, dr1_s_q, ovr_q, done_q, busy};
      3'd3: readdata = {4'd0, irqen_q, dir_q, ce_q, cs_q};
      3'd4: readdata = div_q;
      default: readdata = 8'd0;
    endcase
  end

  assign nrf_clk      = (state_q == HIGH);
  assign nrf_data_out = sh_q[7];
  assign nrf_data_oe  = ~dir_q;
  assign nrf_cs       = cs_q;
  assign nrf_ce       = ce_q;
  assign irq          = irqen_q & (done_q | dr1_s_q);

endmodule
